// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared constants and state type for the 4:1 round-robin mux arbiter
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mux4_datapath.sv
// rtl/mux4_datapath.sv - combinational DATA_W-wide 4:1 data mux steered by the grant select
module mux4_datapath
  import mux_arb_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] i0,
  input  logic [DATA_W-1:0] i1,
  input  logic [DATA_W-1:0] i2,
  input  logic [DATA_W-1:0] i3,
  output logic [DATA_W-1:0] dout
);

  always_comb begin
    case (sel)
      2'd0:    dout = i0;
      2'd1:    dout = i1;
      2'd2:    dout = i2;
      default: dout = i3;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter over four requesters feeding a registered-grant 4:1 mux
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W = 1,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [DATA_W-1:0]     i0,
  input  logic [DATA_W-1:0]     i1,
  input  logic [DATA_W-1:0]     i2,
  input  logic [DATA_W-1:0]     i3,
  input  logic                  out_ready,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [SEL_W-1:0]      sel,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     dout,
  output logic [NUM_REQ-1:0]    ack,
  output logic [CNT_W-1:0]      xfer_cnt
);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic [SEL_W-1:0]   sel_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   cnt_d;
  logic [NUM_REQ-1:0] mask;
  logic [SEL_W:0]     pick;
  logic               xfer;

  // Returns {found, index}: first unmasked requester scanning from l+1 around to l.
  function automatic logic [SEL_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [NUM_REQ-1:0] m,
                                             input logic [SEL_W-1:0]   l);
    logic [NUM_REQ-1:0] cand;
    logic [SEL_W-1:0]   idx;
    logic [SEL_W-1:0]   win;
    logic               found;
    cand  = r & ~m;
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = l + SEL_W'(k);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  assign out_valid = (state_q == GRANT);
  assign xfer      = out_valid && out_ready;
  assign ack       = out_ready ? gnt : '0;

  // A completing transfer re-arbitrates in the same cycle with the winner excluded.
  assign mask   = xfer ? gnt : '0;
  assign last_d = xfer ? sel : last_q;
  assign cnt_d  = xfer ? xfer_cnt + CNT_W'(1) : xfer_cnt;
  assign pick   = rr_pick(req, mask, last_d);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    sel_d   = sel;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick[SEL_W]) begin
          state_d                 = GRANT;
          sel_d                   = pick[SEL_W-1:0];
          gnt_d[pick[SEL_W-1:0]]  = 1'b1;
        end
      end
      GRANT: begin
        if (xfer && pick[SEL_W]) begin
          sel_d                   = pick[SEL_W-1:0];
          gnt_d                   = '0;
          gnt_d[pick[SEL_W-1:0]]  = 1'b1;
        end else if (xfer || !req[sel]) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt      <= '0;
      sel      <= '0;
      last_q   <= SEL_W'(NUM_REQ - 1);
      xfer_cnt <= '0;
    end else begin
      state_q  <= state_d;
      gnt      <= gnt_d;
      sel      <= sel_d;
      last_q   <= last_d;
      xfer_cnt <= cnt_d;
    end
  end

  mux4_datapath #(
    .DATA_W (DATA_W)
  ) u_datapath (
    .sel  (sel),
    .i0   (i0),
    .i1   (i1),
    .i2   (i2),
    .i3   (i3),
    .dout (dout)
  );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - scoreboard bench for the round-robin mux arbiter
module tb_mux4_rr_arbiter;

  localparam int DATA_W = 1;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [3:0]        req = '0;
  logic [DATA_W-1:0] i0 = 1'b0, i1 = 1'b1, i2 = 1'b0, i3 = 1'b1;
  logic              out_ready = 1'b0;
  logic [3:0]        gnt, ack;
  logic [1:0]        sel;
  logic              out_valid;
  logic [DATA_W-1:0] dout;
  logic [CNT_W-1:0]  xfer_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .i0(i0), .i1(i1), .i2(i2), .i3(i3),
    .out_ready(out_ready), .gnt(gnt), .sel(sel), .out_valid(out_valid),
    .dout(dout), .ack(ack), .xfer_cnt(xfer_cnt)
  );

  function automatic logic [DATA_W-1:0] data_of(input int k);
    case (k)
      0: return i0;
      1: return i1;
      2: return i2;
      default: return i3;
    endcase
  endfunction

  // Every completed transfer must match the oldest expected winner.
  always @(negedge clk) begin : sb_monitor
    int e;
    if (rst_n && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL sb_unexpected: transfer with gnt=%b sel=%0d, none expected", gnt, sel);
      end else begin
        e = exp_q.pop_front();
        if (gnt !== 4'(1 << e) || sel !== 2'(e) || ack !== 4'(1 << e) || dout !== data_of(e)) begin
          n_fail++;
          $display("FAIL sb_xfer: got gnt=%b sel=%0d ack=%b dout=%b, want gnt=%b sel=%0d ack=%b dout=%b",
                   gnt, sel, ack, dout, 4'(1 << e), e, 4'(1 << e), data_of(e));
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; req = '0; out_ready = 1'b0;
    tick; tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req = 4'b1111; out_ready = 1'b1;
    tick; tick;
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rst_gnt: got %b want 0000", gnt); end
    n_checks++; if (sel !== 2'd0) begin n_fail++; $display("FAIL rst_sel: got %0d want 0", sel); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL rst_ack: got %b want 0000", ack); end
    n_checks++; if (xfer_cnt !== '0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", xfer_cnt); end
    req = '0; out_ready = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_round_robin;
    int n;
    do_reset;
    req = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) exp_q.push_back(k % 4);
    tick;
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL rr_first: got gnt=%b want 0001", gnt); end
    n = 0;
    while (exp_q.size() != 0 && n < 12) begin tick; n++; end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL rr_timeout: %0d transfers outstanding, want 0", exp_q.size()); exp_q.delete();
    end
    n_checks++; if (xfer_cnt !== 4'd5) begin n_fail++; $display("FAIL rr_cnt: got %0d want 5", xfer_cnt); end
    req = '0; out_ready = 1'b0;
    tick;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rr_idle_valid: got %b want 0", out_valid); end
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rr_idle_gnt: got %b want 0000", gnt); end
    n_checks++; if (sel !== 2'd1) begin n_fail++; $display("FAIL rr_sel_hold: got %0d want 1", sel); end
    n_checks++; if (xfer_cnt !== 4'd5) begin n_fail++; $display("FAIL rr_abort_cnt: got %0d want 5", xfer_cnt); end
  endtask

  task automatic test_select_data;
    int         k;
    logic [1:0] sexp;
    logic       dexp;
    do_reset;
    for (int s = 0; s < 3; s++) begin
      k    = (s == 0) ? 0 : (s == 1) ? 2 : 3;
      sexp = 2'(k);
      dexp = (s == 2);
      req = 4'(1 << k); out_ready = 1'b1; exp_q.push_back(k);
      tick;
      n_checks++; if (sel !== sexp) begin n_fail++; $display("FAIL sd_sel[%0d]: got %0d want %0d", s, sel, sexp); end
      n_checks++; if (dout !== dexp) begin n_fail++; $display("FAIL sd_dout[%0d]: got %b want %b", s, dout, dexp); end
      tick;
      req = '0;
      n_checks++; if (xfer_cnt !== 4'(s + 1)) begin n_fail++; $display("FAIL sd_cnt[%0d]: got %0d want %0d", s, xfer_cnt, s + 1); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sd_idle[%0d]: got %b want 0", s, out_valid); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_hold_and_noise;
    do_reset;
    req = 4'b0010; out_ready = 1'b0;
    tick;
    for (int c = 0; c < 5; c++) begin
      n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL hold_gnt[%0d]: got %b want 0010", c, gnt); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d]: got %b want 1", c, out_valid); end
      n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL hold_ack[%0d]: got %b want 0000", c, ack); end
      n_checks++; if (dout !== 1'b1) begin n_fail++; $display("FAIL hold_dout[%0d]: got %b want 1", c, dout); end
      req = 4'b0010 | (4'($urandom) & 4'b1101);
      i0 = 1'($urandom); i2 = 1'($urandom); i3 = 1'($urandom);
      tick;
    end
    i0 = 1'b0; i2 = 1'b0; i3 = 1'b1; req = 4'b0010;
    n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL noise_gnt: got %b want 0010", gnt); end
    out_ready = 1'b1; exp_q.push_back(1);
    #1;
    n_checks++; if (ack !== 4'b0010) begin n_fail++; $display("FAIL hold_ack_pulse: got %b want 0010", ack); end
    tick;
    n_checks++; if (xfer_cnt !== 4'd1) begin n_fail++; $display("FAIL hold_cnt: got %0d want 1", xfer_cnt); end
    n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL hold_ack_end: got %b want 0000", ack); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_idle: got %b want 0", out_valid); end
    req = '0; out_ready = 1'b0;
  endtask

  task automatic test_abort;
    do_reset;
    req = 4'b0010; out_ready = 1'b0;
    tick;
    n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL ab_gnt: got %b want 0010", gnt); end
    req = '0;
    tick;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ab_valid: got %b want 0", out_valid); end
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL ab_gnt0: got %b want 0000", gnt); end
    n_checks++; if (xfer_cnt !== 4'd0) begin n_fail++; $display("FAIL ab_cnt: got %0d want 0", xfer_cnt); end
    n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL ab_ack: got %b want 0000", ack); end
    req = 4'b0011; out_ready = 1'b1; exp_q.push_back(0); exp_q.push_back(1);
    tick;
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL ab_regrant: got %b want 0001", gnt); end
    tick;
    req = 4'b0010;
    n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL ab_b2b: got %b want 0010", gnt); end
    tick;
    req = '0; out_ready = 1'b0;
    n_checks++; if (xfer_cnt !== 4'd2) begin n_fail++; $display("FAIL ab_cnt2: got %0d want 2", xfer_cnt); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ab_idle: got %b want 0", out_valid); end
  endtask

  task automatic test_async_reset;
    do_reset;
    req = 4'b0001; out_ready = 1'b1; exp_q.push_back(0);
    tick; tick;
    req = '0;
    n_checks++; if (xfer_cnt !== 4'd1) begin n_fail++; $display("FAIL ar_pre_cnt: got %0d want 1", xfer_cnt); end
    out_ready = 1'b0; req = 4'b0100;
    tick;
    n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL ar_pre_gnt: got %b want 0100", gnt); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL ar_gnt: got %b want 0000", gnt); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b want 0", out_valid); end
    n_checks++; if (xfer_cnt !== 4'd0) begin n_fail++; $display("FAIL ar_cnt: got %0d want 0", xfer_cnt); end
    n_checks++; if (sel !== 2'd0) begin n_fail++; $display("FAIL ar_sel: got %0d want 0", sel); end
    req = 4'b1000;
    tick;
    rst_n = 1'b1;
    tick;
    n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL ar_post_gnt: got %b want 1000", gnt); end
    n_checks++; if (sel !== 2'd3) begin n_fail++; $display("FAIL ar_post_sel: got %0d want 3", sel); end
    req = '0;
    tick;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_post_idle: got %b want 0", out_valid); end
  endtask

  task automatic test_wrap;
    do_reset;
    req = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 16; k++) exp_q.push_back(k % 4);
    tick;
    for (int t = 1; t <= 16; t++) begin
      tick;
      if (t == 15) begin
        n_checks++; if (xfer_cnt !== 4'd15) begin n_fail++; $display("FAIL wrap_cnt15: got %0d want 15", xfer_cnt); end
      end
    end
    n_checks++; if (xfer_cnt !== 4'd0) begin n_fail++; $display("FAIL wrap_cnt0: got %0d want 0", xfer_cnt); end
    req = '0; out_ready = 1'b0;
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_round_robin;
    test_select_data;
    test_hold_and_noise;
    test_abort;
    test_async_reset;
    test_wrap;
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_drain: %0d expected transfers never seen, want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
